mem_dma_master: RTL and testbench

MEM_DMA_MASTER -- requirements
Module: mem_dma_master

---
 rtl/mem_dma_master_if.sv | 36 +++
 rtl/mem_dma_master.sv | 144 ++++++++++++++
 tb/tb_mem_dma_master.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_master_if.sv
// mem_dma_master_if: native memory bus between a DMA initiator and a memory
// responder.
//
// Handshake: the initiator raises mem_valid together with mem_addr, mem_wdata
// and mem_wstrb, and holds all of them stable until the responder answers with
// mem_ready in the same cycle as mem_valid. A transfer completes on every
// rising edge where mem_valid && mem_ready. mem_ready seen without mem_valid
// means nothing. mem_rdata only matters in the completing cycle of a read.
//
// Signals:
//   mem_valid  initiator -> responder  request valid
//   mem_instr  initiator -> responder  instruction fetch flag (always 0 here)
//   mem_addr   initiator -> responder  word-aligned byte address
//   mem_wdata  initiator -> responder  write data
//   mem_wstrb  initiator -> responder  byte strobes, 0000 = read
//   mem_ready  responder -> initiator  acknowledge
//   mem_rdata  responder -> initiator  read data
interface mem_dma_master_if;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_dma_master.sv
// mem_dma_master: copies len 32-bit words from src_addr to dst_addr over a
// native valid/ready memory bus, one read followed by one write per word,
// with one idle bus cycle between accesses.
//
// Ports:
//   clk        clock, rising edge
//   resetn     synchronous active-low reset
//   start      request pulse, only looked at while idle
//   src_addr   first source byte address (bits [1:0] ignored)
//   dst_addr   first destination byte address (bits [1:0] ignored)
//   len        number of words to copy (0 completes with no bus traffic)
//   busy       high whenever not idle
//   done       one-cycle completion pulse
//   state_dbg  current FSM state
//   bus        memory bus, initiator side
module mem_dma_master #(
    parameter int LEN_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           state_dbg,
    mem_dma_master_if.master     bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] RD2WR = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] WR2RD = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]           state;
    logic [31:0]          src_ptr;
    logic [31:0]          dst_ptr;
    logic [LEN_WIDTH-1:0] remaining;
    logic [31:0]          data_reg;

    logic                 valid_q;
    logic [31:0]          addr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           wstrb_q;
    logic                 busy_q;
    logic                 done_q;

    // Every bus output is a flop loaded on the edge that enters the state
    // using it, so nothing on the bus can move while a request waits.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            data_reg  <= '0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= {src_addr[31:2], 2'b00};
                        dst_ptr   <= {dst_addr[31:2], 2'b00};
                        remaining <= len;
                        busy_q    <= 1'b1;
                        if (len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= READ;
                            valid_q <= 1'b1;
                            addr_q  <= {src_addr[31:2], 2'b00};
                            wstrb_q <= 4'b0000;
                        end
                    end
                end
                READ: begin
                    if (bus.mem_ready) begin
                        data_reg <= bus.mem_rdata;
                        valid_q  <= 1'b0;
                        state    <= RD2WR;
                    end
                end
                RD2WR: begin
                    state   <= WRITE;
                    valid_q <= 1'b1;
                    addr_q  <= dst_ptr;
                    wdata_q <= data_reg;
                    wstrb_q <= 4'b1111;
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        // 32-bit adds wrap naturally past 0xFFFFFFFC.
                        src_ptr   <= src_ptr + 32'd4;
                        dst_ptr   <= dst_ptr + 32'd4;
                        remaining <= remaining - 1'b1;
                        valid_q   <= 1'b0;
                        wstrb_q   <= 4'b0000;
                        if (remaining == LEN_WIDTH'(1)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= WR2RD;
                        end
                    end
                end
                WR2RD: begin
                    state   <= READ;
                    valid_q <= 1'b1;
                    addr_q  <= src_ptr;
                    wstrb_q <= 4'b0000;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_valid = valid_q;
    assign bus.mem_instr = 1'b0;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_mem_dma_master.sv
module tb_mem_dma_master;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [11:0] len;
    logic        busy;
    logic        done;
    logic [2:0]  state_dbg;

    mem_dma_master_if bus ();

    mem_dma_master #(.LEN_WIDTH(12)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg),
        .bus       (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- responder: 4 KB RAM with programmable wait states ----------------
    logic [31:0] ram [0:1023];
    logic [3:0]  wait_cfg = 4'd0;
    logic [3:0]  wait_cnt = 4'd0;
    logic        ld_en = 1'b0;
    logic [9:0]  ld_idx = '0;
    logic [31:0] ld_data = '0;

    assign bus.mem_ready = bus.mem_valid && (wait_cnt == wait_cfg);
    assign bus.mem_rdata = ram[bus.mem_addr[11:2]];

    always @(posedge clk) begin
        if (bus.mem_valid && !bus.mem_ready) wait_cnt <= wait_cnt + 4'd1;
        else                                 wait_cnt <= 4'd0;
        if (ld_en) ram[ld_idx] <= ld_data;
        else if (bus.mem_valid && bus.mem_ready && bus.mem_wstrb == 4'hF)
            ram[bus.mem_addr[11:2]] <= bus.mem_wdata;
    end

    // ---------------- scoreboard ----------------
    logic [64:0] exp_q[$];       // {is_write, addr, data}
    logic [31:0] exp_done_q[$];  // cycle number of expected done pulse
    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt = 0, valid_cnt = 0, busy_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_wstrb;

    always @(negedge clk) begin
        logic [64:0] e;
        if (bus.mem_valid) valid_cnt++;
        if (busy) busy_cnt++;
        if (bus.mem_valid && prev_wait) begin
            check("stall_addr",  bus.mem_addr,  prev_addr);
            check("stall_wdata", bus.mem_wdata, prev_wdata);
            check("stall_wstrb", bus.mem_wstrb, prev_wstrb);
        end
        prev_wait  = bus.mem_valid && !bus.mem_ready;
        prev_addr  = bus.mem_addr;
        prev_wdata = bus.mem_wdata;
        prev_wstrb = bus.mem_wstrb;
        if (bus.mem_valid && bus.mem_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_handshake", bus.mem_addr, 64'hFFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("hs_wstrb", bus.mem_wstrb, e[64] ? 4'hF : 4'h0);
                check("hs_addr",  bus.mem_addr,  e[63:32]);
                check("hs_instr", bus.mem_instr, 0);
                if (e[64]) check("hs_wdata", bus.mem_wdata, e[31:0]);
            end
        end
        if (done) begin
            if (exp_done_q.size() == 0) check("unexpected_done", cyc, 64'hFFFF_FFFF_FFFF);
            else check("done_cycle", cyc, exp_done_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = addr[11:2]; ld_data = data;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Pulses start for one cycle; if exp_en, pushes the full expected
    // handshake sequence and done cycle computed from the bench's RAM copy.
    task automatic run(input logic [31:0] s, input logic [31:0] d,
                       input logic [11:0] l, input bit exp_en);
        logic [31:0] sa, da;
        int base;
        @(negedge clk);
        base = cyc;
        sa = {s[31:2], 2'b00};
        da = {d[31:2], 2'b00};
        if (exp_en) begin
            for (int i = 0; i < int'(l); i++) begin
                exp_q.push_back({1'b0, sa, ram[sa[11:2]]});
                exp_q.push_back({1'b1, da, ram[sa[11:2]]});
                sa = sa + 32'd4;
                da = da + 32'd4;
            end
            if (l == 0) exp_done_q.push_back(base + 1);
            else        exp_done_q.push_back(base + 4 * int'(l) + 2 * int'(l) * int'(wait_cfg));
        end
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (exp_done_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (exp_done_q.size() != 0) check("done_timeout", n, 0);
        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        resetn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bus.mem_valid, 0);
        check("rst_addr",  bus.mem_addr,  0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_wstrb", bus.mem_wstrb, 0);
        check("rst_instr", bus.mem_instr, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_state", state_dbg, 0);
        resetn = 1'b1;

        // Basic 4-word copy, zero-wait
        preload(32'h100, 32'hA0); preload(32'h104, 32'hA1);
        preload(32'h108, 32'hA2); preload(32'h10C, 32'hA3);
        hs_cnt = 0;
        run(32'h100, 32'h200, 12'd4, 1'b1);
        wait_done(100);
        check("copy_hs_count", hs_cnt, 8);
        check("copy_w0", ram[32'h200 >> 2], 32'hA0);
        check("copy_w1", ram[32'h204 >> 2], 32'hA1);
        check("copy_w2", ram[32'h208 >> 2], 32'hA2);
        check("copy_w3", ram[32'h20C >> 2], 32'hA3);

        // len = 0: done at cycle 1, no bus traffic, busy for one cycle
        valid_cnt = 0; busy_cnt = 0;
        run(32'h100, 32'h200, 12'd0, 1'b1);
        wait_done(20);
        check("len0_valid_cycles", valid_cnt, 0);
        check("len0_busy_cycles",  busy_cnt,  1);

        // 3 wait states per access, len = 2: done at cycle 20
        preload(32'h110, 32'h1234_5678); preload(32'h114, 32'h9ABC_DEF0);
        wait_cfg = 4'd3;
        run(32'h110, 32'h220, 12'd2, 1'b1);
        wait_done(100);
        check("wait_w0", ram[32'h220 >> 2], 32'h1234_5678);
        check("wait_w1", ram[32'h224 >> 2], 32'h9ABC_DEF0);
        wait_cfg = 4'd0;

        // Source pointer wraps past 0xFFFFFFFC; misaligned addresses are truncated
        preload(32'hFFFF_FFFC, 32'hC0DE_0001); preload(32'h0, 32'hC0DE_0002);
        run(32'hFFFF_FFFC, 32'h10, 12'd2, 1'b1);
        wait_done(50);
        check("wrap_w0", ram[32'h10 >> 2], 32'hC0DE_0001);
        check("wrap_w1", ram[32'h14 >> 2], 32'hC0DE_0002);
        run(32'h103, 32'h303, 12'd1, 1'b1);
        wait_done(50);
        check("unaligned_w0", ram[32'h300 >> 2], 32'hA0);

        // start while busy is ignored
        run(32'h100, 32'h240, 12'd3, 1'b1);
        repeat (4) @(negedge clk);
        src_addr = 32'h500; dst_addr = 32'h600; len = 12'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        repeat (5) @(negedge clk);
        check("ignored_start_w2", ram[32'h248 >> 2], 32'hA2);

        // Reset while a write waits on mem_ready
        wait_cfg = 4'd5;
        run(32'h100, 32'h400, 12'd1, 1'b0);
        exp_q.push_back({1'b0, 32'h100, ram[32'h100 >> 2]});
        n = 0;
        while (!(bus.mem_valid && bus.mem_wstrb == 4'hF) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_write_wait", bus.mem_valid && bus.mem_wstrb == 4'hF, 1);
        resetn = 1'b0;
        @(negedge clk);
        check("abort_valid", bus.mem_valid, 0);
        check("abort_busy",  busy, 0);
        check("abort_state", state_dbg, 0);
        check("abort_read_seen", exp_q.size(), 0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        wait_cfg = 4'd0;
        run(32'h104, 32'h404, 12'd1, 1'b1);
        wait_done(30);
        check("after_abort_w0", ram[32'h404 >> 2], 32'hA1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
